// File: rtl/eth_rx_parser.sv
// eth_rx_parser: GMII receive parser for Ethernet/IPv4/UDP/ARP/ICMP with UDP payload streaming.
module eth_rx_parser #(
  parameter int MIN_PREAMBLE = 2,
  parameter bit CHECK_IP_DST = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [47:0] mac_s_addr,
  input  logic [31:0] ip_s_addr,
  input  logic [15:0] port_s,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic [15:0] udp_len,
  output logic        arp_request_done,
  output logic        arp_oper,
  output logic        icmp_request_done,
  output logic [15:0] icmp_id,
  output logic [15:0] icmp_seq_num,
  output logic [47:0] mac_d_addr,
  output logic [31:0] ip_d_addr,
  output logic        rx_err
);
  typedef enum logic [3:0] {IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, UDP_DATA, ARP_DATA, ICMP_HDR, DROP} state_t;
  localparam logic [55:0] ARP_FIX = 56'h0001_0800_0604_00;
  state_t      state;
  logic [5:0]  cnt;
  logic [15:0] pay_cnt;
  logic [23:0] sh;
  logic [47:0] smac;
  logic [31:0] sip;
  logic        ok, bc, is_icmp, oper_req, bad;
  logic [15:0] et;
  logic [7:0]  mac_b, ip_b, arp_b;
  assign et    = {sh[7:0], gmii_rxd};
  assign mac_b = 8'(mac_s_addr >> {3'd5 - cnt[2:0], 3'b000});
  assign ip_b  = 8'(ip_s_addr >> {2'd3 - cnt[1:0], 3'b000});
  assign arp_b = 8'(ARP_FIX >> {3'd6 - cnt[2:0], 3'b000});
  // Any header field mismatch sends the frame straight to DROP without touching outputs.
  always_comb begin
    bad = (state == ETH_HDR)  ? (cnt == 6'd13 && (!(ok || bc) || (et != 16'h0800 && et != 16'h0806))) :
          (state == IP_HDR)   ? ((cnt == 6'd0 && gmii_rxd != 8'h45) ||
                                 (cnt == 6'd9 && gmii_rxd != 8'h11 && gmii_rxd != 8'h01) ||
                                 (CHECK_IP_DST && cnt >= 6'd16 && gmii_rxd != ip_b)) :
          (state == UDP_HDR)  ? ((cnt == 6'd2 && gmii_rxd != port_s[15:8]) ||
                                 (cnt == 6'd3 && gmii_rxd != port_s[7:0]) ||
                                 (cnt == 6'd5 && et <= 16'd8)) :
          (state == ARP_DATA) ? ((cnt < 6'd7 && gmii_rxd != arp_b) ||
                                 (cnt == 6'd7 && gmii_rxd != 8'h01 && gmii_rxd != 8'h02) ||
                                 (cnt >= 6'd24 && gmii_rxd != ip_b)) :
          (state == ICMP_HDR) ? ((cnt == 6'd0 && gmii_rxd != 8'h08) || (cnt == 6'd1 && gmii_rxd != 8'h00)) :
          1'b0;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      cnt <= '0;
      pay_cnt <= '0;
      sh <= '0;
      smac <= '0;
      sip <= '0;
      ok <= 1'b0;
      bc <= 1'b0;
      is_icmp <= 1'b0;
      oper_req <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      udp_len <= '0;
      arp_request_done <= 1'b0;
      arp_oper <= 1'b0;
      icmp_request_done <= 1'b0;
      icmp_id <= '0;
      icmp_seq_num <= '0;
      mac_d_addr <= '0;
      ip_d_addr <= '0;
      rx_err <= 1'b0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      arp_request_done <= 1'b0;
      icmp_request_done <= 1'b0;
      rx_err <= 1'b0;
      if (!gmii_rx_dv) begin
        rx_err <= (state == UDP_DATA);
        state <= IDLE;
      end else if (gmii_rx_er) begin
        rx_err <= (state == UDP_DATA);
        state <= DROP;
      end else if (bad) begin
        state <= DROP;
      end else begin
        cnt <= cnt + 6'd1;
        sh <= {sh[15:0], gmii_rxd};
        case (state)
          IDLE: begin
            state <= (gmii_rxd == 8'h55) ? PREAMBLE : DROP;
            cnt <= 6'd1;
          end
          PREAMBLE: begin
            if (gmii_rxd == 8'h55) cnt <= (cnt == 6'd63) ? cnt : cnt + 6'd1;
            else if (gmii_rxd == 8'hD5 && cnt >= 6'(MIN_PREAMBLE)) begin
              state <= ETH_HDR;
              cnt <= '0;
              ok <= 1'b1;
              bc <= 1'b1;
            end else state <= DROP;
          end
          ETH_HDR: begin
            if (cnt < 6'd6) begin
              ok <= ok && (gmii_rxd == mac_b);
              bc <= bc && (gmii_rxd == 8'hFF);
            end else if (cnt < 6'd12) smac <= {smac[39:0], gmii_rxd};
            if (cnt == 6'd13) begin
              cnt <= '0;
              state <= (et == 16'h0800) ? IP_HDR : ARP_DATA;
            end
          end
          IP_HDR: begin
            if (cnt == 6'd9) is_icmp <= (gmii_rxd == 8'h01);
            if (cnt >= 6'd12 && cnt < 6'd16) sip <= {sip[23:0], gmii_rxd};
            if (cnt == 6'd19) begin
              cnt <= '0;
              state <= is_icmp ? ICMP_HDR : UDP_HDR;
            end
          end
          UDP_HDR: if (cnt == 6'd7) begin
            udp_len <= sh[23:8];
            pay_cnt <= sh[23:8] - 16'd8;
            mac_d_addr <= smac;
            ip_d_addr <= sip;
            state <= UDP_DATA;
          end
          UDP_DATA: begin
            m_axis_tdata <= gmii_rxd;
            m_axis_tvalid <= 1'b1;
            pay_cnt <= pay_cnt - 16'd1;
            if (pay_cnt == 16'd1) begin
              m_axis_tlast <= 1'b1;
              state <= DROP;
            end
          end
          ARP_DATA: begin
            if (cnt == 6'd7) oper_req <= (gmii_rxd == 8'h01);
            if (cnt >= 6'd8 && cnt < 6'd14) smac <= {smac[39:0], gmii_rxd};
            if (cnt >= 6'd14 && cnt < 6'd18) sip <= {sip[23:0], gmii_rxd};
            if (cnt == 6'd27) begin
              mac_d_addr <= smac;
              ip_d_addr <= sip;
              arp_oper <= oper_req;
              arp_request_done <= 1'b1;
              state <= DROP;
            end
          end
          ICMP_HDR: if (cnt == 6'd7) begin
            icmp_id <= sh[23:8];
            icmp_seq_num <= et;
            mac_d_addr <= smac;
            ip_d_addr <= sip;
            icmp_request_done <= 1'b1;
            state <= DROP;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_eth_rx_parser.sv
// tb_eth_rx_parser: randomized frames scored against an offset-based frame model with a decoupled monitor.
module tb_eth_rx_parser;
  localparam logic [47:0] MAC  = 48'h02_00_00_12_34_56;
  localparam logic [31:0] IP   = 32'hC0A8_0101;
  localparam logic [15:0] PORT = 16'd5000;
  logic aclk, aresetn, gmii_rx_dv, gmii_rx_er;
  logic [7:0] gmii_rxd, m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, arp_request_done, arp_oper, icmp_request_done, rx_err;
  logic [15:0] udp_len, icmp_id, icmp_seq_num;
  logic [47:0] mac_d_addr;
  logic [31:0] ip_d_addr;
  int checks, failures;
  logic [7:0] fb[$];
  logic [7:0] pay[$];
  logic [9:0] exp_q[$];
  int ev_q[$];
  int f_pre, pay_off;
  logic [47:0] f_dst, f_src;
  logic [31:0] f_sip, f_dip, f_tpa;
  logic [15:0] f_et, f_dport, f_len, f_id, f_seq, f_oper;
  logic [7:0] f_ver, f_proto, f_type, f_code;
  logic [15:0] m_len, m_id, m_seq;
  logic [47:0] m_mac;
  logic [31:0] m_ip;
  logic m_oper;

  eth_rx_parser dut (
    .aclk(aclk), .aresetn(aresetn), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .mac_s_addr(MAC), .ip_s_addr(IP), .port_s(PORT),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .udp_len(udp_len), .arp_request_done(arp_request_done), .arp_oper(arp_oper),
    .icmp_request_done(icmp_request_done), .icmp_id(icmp_id), .icmp_seq_num(icmp_seq_num),
    .mac_d_addr(mac_d_addr), .ip_d_addr(ip_d_addr), .rx_err(rx_err)
  );

  initial aclk = 1'b0;
  always #4 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] getn(input int off, input int n);
    logic [47:0] v = '0;
    for (int k = 0; k < n; k++) v = {v[39:0], fb[off + k]};
    return v;
  endfunction

  task automatic model_clear();
    m_len = '0; m_id = '0; m_seq = '0; m_mac = '0; m_ip = '0; m_oper = 1'b0;
  endtask

  // Walks the frame by field offsets; only bytes before cut are seen by the parser.
  task automatic model(input int cut);
    int i, e, h, u, a, pl, n;
    logic [47:0] dst, smac;
    logic [31:0] sip;
    logic [15:0] et, len, op;
    i = 0;
    while (i < cut && fb[i] == 8'h55) i++;
    if (i < 2 || i >= cut || fb[i] != 8'hD5) return;
    e = i + 1;
    if (e + 14 > cut) return;
    dst = getn(e, 6);
    if (dst != MAC && dst != 48'hFFFF_FFFF_FFFF) return;
    smac = getn(e + 6, 6);
    et = 16'(getn(e + 12, 2));
    if (et == 16'h0800) begin
      h = e + 14;
      u = h + 20;
      if (u > cut || fb[h] != 8'h45 || 32'(getn(h + 16, 4)) != IP) return;
      sip = 32'(getn(h + 12, 4));
      if (u + 8 > cut) return;
      if (fb[h + 9] == 8'h11) begin
        if (16'(getn(u + 2, 2)) != PORT) return;
        len = 16'(getn(u + 4, 2));
        if (len <= 16'd8) return;
        m_len = len; m_mac = smac; m_ip = sip;
        pl = int'(len) - 8;
        n = cut - (u + 8);
        if (n > pl) n = pl;
        for (int k = 0; k < n; k++) exp_q.push_back({1'b1, k == pl - 1, fb[u + 8 + k]});
        if (n < pl) ev_q.push_back(3);
      end else if (fb[h + 9] == 8'h01) begin
        if (fb[u] != 8'h08 || fb[u + 1] != 8'h00) return;
        m_id = 16'(getn(u + 4, 2)); m_seq = 16'(getn(u + 6, 2)); m_mac = smac; m_ip = sip;
        ev_q.push_back(2);
      end
    end else if (et == 16'h0806) begin
      a = e + 14;
      if (a + 28 > cut || getn(a, 6) != 48'h0001_0800_0604 || 32'(getn(a + 24, 4)) != IP) return;
      op = 16'(getn(a + 6, 2));
      if (op != 16'd1 && op != 16'd2) return;
      m_mac = getn(a + 8, 6); m_ip = 32'(getn(a + 14, 4)); m_oper = (op == 16'd1);
      ev_q.push_back(1);
    end
  endtask

  task automatic put(input logic [47:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) fb.push_back(v[8*k +: 8]);
  endtask

  task automatic defaults(input int kind);
    f_pre = $urandom_range(2, 8);
    f_dst = $urandom_range(0, 1) ? MAC : 48'hFFFF_FFFF_FFFF;
    f_src = {16'($urandom), 32'($urandom)};
    f_et = (kind == 1) ? 16'h0806 : (kind == 3) ? 16'($urandom) : 16'h0800;
    f_ver = 8'h45;
    f_proto = (kind == 2) ? 8'h01 : 8'h11;
    f_sip = $urandom;
    f_dip = IP;
    f_dport = PORT;
    pay.delete();
    repeat ($urandom_range(1, 16)) pay.push_back(8'($urandom));
    f_len = 16'(8 + pay.size());
    f_type = 8'h08; f_code = 8'h00;
    f_id = 16'($urandom); f_seq = 16'($urandom);
    f_oper = 16'($urandom_range(1, 2));
    f_tpa = IP;
  endtask

  task automatic build();
    fb.delete();
    repeat (f_pre) put(48'h55, 1);
    put(48'hD5, 1); put(f_dst, 6); put(f_src, 6); put(48'(f_et), 2);
    pay_off = 0;
    if (f_et == 16'h0806) begin
      put(48'h0001_0800_0604, 6); put(48'(f_oper), 2); put(f_src, 6); put(48'(f_sip), 4);
      put(48'h0, 6); put(48'(f_tpa), 4);
    end else if (f_et == 16'h0800) begin
      put(48'(f_ver), 1); put(48'h0, 1); put(48'(28 + pay.size()), 2); put(48'($urandom), 4);
      put(48'h40, 1); put(48'(f_proto), 1); put(48'($urandom), 2); put(48'(f_sip), 4); put(48'(f_dip), 4);
      if (f_proto == 8'h01) begin
        put(48'(f_type), 1); put(48'(f_code), 1); put(48'($urandom), 2); put(48'(f_id), 2); put(48'(f_seq), 2);
      end else begin
        put(48'($urandom), 2); put(48'(f_dport), 2); put(48'(f_len), 2); put(48'($urandom), 2);
      end
      pay_off = fb.size();
      foreach (pay[k]) fb.push_back(pay[k]);
    end else repeat (20) put(48'($urandom), 1);
    repeat ($urandom_range(4, 8)) put(48'($urandom), 1);
  endtask

  task automatic check_state();
    repeat (3) @(negedge aclk);
    chk("beats_pending", 64'(exp_q.size()), 0);
    chk("events_pending", 64'(ev_q.size()), 0);
    exp_q.delete(); ev_q.delete();
    chk("udp_len", 64'(udp_len), 64'(m_len));
    chk("mac_d_addr", 64'(mac_d_addr), 64'(m_mac));
    chk("ip_d_addr", 64'(ip_d_addr), 64'(m_ip));
    chk("arp_oper", 64'(arp_oper), 64'(m_oper));
    chk("icmp_id", 64'(icmp_id), 64'(m_id));
    chk("icmp_seq_num", 64'(icmp_seq_num), 64'(m_seq));
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_addrs"}, {mac_d_addr, udp_len}, 0);
    chk({nm, "_ip"}, 64'(ip_d_addr), 0);
    chk({nm, "_misc"}, {m_axis_tdata, m_axis_tvalid, m_axis_tlast, arp_request_done, arp_oper,
                        icmp_request_done, icmp_id, icmp_seq_num, rx_err}, 0);
  endtask

  task automatic send(input int er_idx, input int gap, input int rst_idx, input bit chk_after);
    int cut = fb.size();
    if (er_idx >= 0 && er_idx < cut) cut = er_idx;
    if (rst_idx >= 0 && rst_idx < cut) cut = rst_idx;
    model(cut);
    foreach (fb[i]) begin
      @(posedge aclk); #1;
      if (i == rst_idx) begin
        aresetn = 1'b0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0;
        #1;
        check_zero("reset_mid");
        exp_q.delete(); ev_q.delete(); model_clear();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        return;
      end
      gmii_rx_dv = 1'b1; gmii_rxd = fb[i]; gmii_rx_er = (i == er_idx);
    end
    @(posedge aclk); #1;
    gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    repeat (gap - 1) @(posedge aclk);
    if (chk_after) check_state();
  endtask

  // Monitor: pops expectations whenever the DUT presents a beat or a pulse.
  initial begin
    logic [9:0] e;
    int g;
    forever begin
      @(negedge aclk);
      if (m_axis_tvalid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h0;
        chk("beat", {1'b1, m_axis_tlast, m_axis_tdata}, e);
      end
      if (arp_request_done) begin
        g = (ev_q.size() != 0) ? ev_q.pop_front() : 0;
        chk("arp_pulse", g, 1);
      end
      if (icmp_request_done) begin
        g = (ev_q.size() != 0) ? ev_q.pop_front() : 0;
        chk("icmp_pulse", g, 2);
      end
      if (rx_err) begin
        g = (ev_q.size() != 0) ? ev_q.pop_front() : 0;
        chk("rx_err_pulse", g, 3);
      end
    end
  end

  initial begin
    int r, idx;
    checks = 0; failures = 0;
    aresetn = 1'b0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    model_clear();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_zero("reset");
    @(posedge aclk); #1 aresetn = 1'b1;
    // UDP accept
    defaults(0); f_pre = 7; f_dst = MAC;
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; f_len = 16'h000C;
    build(); send(-1, 4, -1, 1);
    chk("udp_len_12", 64'(udp_len), 12);
    // UDP rejects
    f_dport = PORT + 16'd1; build(); send(-1, 4, -1, 1);
    defaults(0); f_et = 16'h86DD; build(); send(-1, 4, -1, 1);
    // ARP accept and TPA mismatch
    defaults(1); f_dst = 48'hFFFF_FFFF_FFFF; f_oper = 16'd1; f_sip = 32'hC0A8_0102;
    build(); send(-1, 4, -1, 1);
    chk("arp_ip", 64'(ip_d_addr), 64'hC0A8_0102);
    f_tpa = IP ^ 32'h1; f_sip = 32'hC0A8_0203; build(); send(-1, 4, -1, 1);
    // ICMP echo and type 0
    defaults(2); f_id = 16'h1234; f_seq = 16'h0007; build(); send(-1, 4, -1, 1);
    chk("icmp_id_1234", 64'(icmp_id), 64'h1234);
    defaults(2); f_type = 8'h00; build(); send(-1, 4, -1, 1);
    // truncated payload and errored payload byte
    defaults(0); pay.delete(); repeat (8) pay.push_back(8'($urandom)); f_len = 16'h0010;
    build(); while (fb.size() > pay_off + 3) void'(fb.pop_back());
    send(-1, 4, -1, 1);
    defaults(0); pay.delete(); repeat (8) pay.push_back(8'($urandom)); f_len = 16'h0010;
    build(); send(pay_off + 1, 4, -1, 1);
    // reset mid payload, then a clean frame
    defaults(0); pay.delete(); repeat (8) pay.push_back(8'($urandom)); f_len = 16'h0010;
    build(); send(-1, 4, pay_off + 2, 0);
    defaults(0); build(); send(-1, 4, -1, 1);
    // back-to-back with a single idle cycle
    defaults(1); build(); send(-1, 1, -1, 0);
    defaults(0); build(); send(-1, 4, -1, 1);
    // preamble boundary and length boundary
    defaults(0); f_pre = 2; build(); send(-1, 4, -1, 1);
    defaults(0); f_pre = 1; build(); send(-1, 4, -1, 1);
    defaults(0); pay.delete(); f_len = 16'd8; build(); send(-1, 4, -1, 1);
    defaults(0); pay.delete(); pay.push_back(8'h5A); f_len = 16'd9; build(); send(-1, 4, -1, 1);
    // randomized traffic with occasional corruption, errors and truncation
    for (int t = 0; t < 60; t++) begin
      defaults($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) f_dst = MAC ^ 48'h1;
      build();
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, fb.size() - 1);
        fb[idx] = fb[idx] ^ 8'(1 << $urandom_range(0, 7));
      end
      r = $urandom_range(0, 5);
      if (r == 0) send($urandom_range(0, fb.size() - 1), $urandom_range(1, 3), -1, 1);
      else begin
        if (r == 1) begin
          idx = $urandom_range(1, fb.size());
          while (fb.size() > idx) void'(fb.pop_back());
        end
        send(-1, $urandom_range(1, 3), -1, 1);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
